// File: rtl/green_pkg.sv
// rtl/green_pkg.sv - shared opcodes, field positions and FSM states for the green decoder
package green_pkg;

  localparam logic [3:0] OPC_LD  = 4'b0000;
  localparam logic [3:0] OPC_ST  = 4'b0001;
  localparam logic [3:0] OPC_INC = 4'b0010;
  localparam logic [3:0] OPC_DEC = 4'b0011;
  localparam logic [3:0] OPC_BRZ = 4'b0100;

  localparam int OPC_MSB = 15;
  localparam int SEL_MSB = 11;
  localparam int OFF_W   = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/green_regbank.sv
// rtl/green_regbank.sv - NREG x W register bank, one write port, flat read-out
module green_regbank #(
  parameter int W    = 16,
  parameter int NREG = 2,
  localparam int RSEL_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [RSEL_W-1:0] wr_sel,
  input  logic [W-1:0]      wr_data,
  output logic [NREG*W-1:0] q
);

  logic [W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_sel] <= wr_data;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign q[g*W +: W] = regs[g];
  end

endmodule

// File: rtl/green_decode_ctrl.sv
// rtl/green_decode_ctrl.sv - clocked green instruction decoder with register bank and store handshake
module green_decode_ctrl
  import green_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [15:0]       ins,
  input  logic [W-1:0]      ld_data,
  output logic [NREG*W-1:0] reg_q,
  output logic              we,
  output logic [W-1:0]      st_data,
  input  logic              st_ack,
  output logic              br,
  output logic [7:0]        br_off,
  output logic              illegal
);

  localparam int RSEL_W = $clog2(NREG);

  state_t            state;
  logic              accept;
  logic [3:0]        opc;
  logic [RSEL_W-1:0] sel;
  logic [W-1:0]      cur;
  logic [W-1:0]      alu;
  logic              wr_en;
  logic              cur_zero;
  logic              unused_ins;

  assign accept     = ins_valid & ins_ready;
  assign opc        = ins[OPC_MSB -: 4];
  assign sel        = ins[SEL_MSB -: RSEL_W];
  assign cur        = reg_q[int'(sel)*W +: W];
  assign cur_zero   = (cur == '0);
  assign unused_ins = ^ins;

  // Only LD/INC/DEC write the bank; wr_en is already gated by accept.
  always_comb begin
    wr_en = 1'b0;
    alu   = cur;
    if (accept) begin
      case (opc)
        OPC_LD:  begin wr_en = 1'b1; alu = ld_data;     end
        OPC_INC: begin wr_en = 1'b1; alu = cur + W'(1); end
        OPC_DEC: begin wr_en = 1'b1; alu = cur - W'(1); end
        default: begin wr_en = 1'b0; alu = cur;         end
      endcase
    end
  end

  green_regbank #(.W(W), .NREG(NREG)) u_regbank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_sel  (sel),
    .wr_data (alu),
    .q       (reg_q)
  );

  // ins_ready resets low so nothing is accepted until the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ins_ready <= 1'b0;
      we        <= 1'b0;
      st_data   <= '0;
      br        <= 1'b0;
      br_off    <= '0;
      illegal   <= 1'b0;
    end else begin
      br      <= 1'b0;
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          ins_ready <= 1'b1;
          if (accept) begin
            case (opc)
              OPC_ST: begin
                we        <= 1'b1;
                st_data   <= cur;
                ins_ready <= 1'b0;
                state     <= ST_WAIT;
              end
              OPC_BRZ: begin
                if (cur_zero) begin
                  br     <= 1'b1;
                  br_off <= ins[OFF_W-1:0];
                end
              end
              OPC_LD, OPC_INC, OPC_DEC: ;
              default: illegal <= 1'b1;
            endcase
          end
        end
        ST_WAIT: begin
          if (st_ack) begin
            we        <= 1'b0;
            ins_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
